// File: rtl/sfp_link_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sfp_link_pkg : shared FSM encodings and sizing helpers for the link |
// | Revision     : 1.0                                                  |
// +--------------------------------------------------------------------+
package sfp_link_pkg;

    typedef enum logic [0:0] {
        TX_IDLE = 1'b0,
        TX_SEND = 1'b1
    } tx_state_e;

    typedef enum logic [1:0] {
        RX_IDLE    = 2'd0,
        RX_COLLECT = 2'd1,
        RX_DROP    = 2'd2
    } rx_state_e;

    function automatic int beats_per_frame(input int word_w, input int beat_w);
        return word_w / beat_w;
    endfunction

    // A counter over n values; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sfp_stream_deser.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sfp_stream_deser : AXIS beats -> wide word assembler with timeout   |
// | Revision         : 1.0                                              |
// +--------------------------------------------------------------------+
module sfp_stream_deser
    import sfp_link_pkg::*;
#(
    parameter int BEAT_W  = 32,
    parameter int WORD_W  = 256,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [BEAT_W-1:0] beat_data_i,
    input  logic              beat_valid_i,
    input  logic              beat_last_i,
    output logic              beat_ready_o,
    output logic [WORD_W-1:0] word_o,
    output logic              word_valid_o,
    output logic              err_o
);
    localparam int N     = beats_per_frame(WORD_W, BEAT_W);
    localparam int CW    = cnt_width(N);
    localparam int GW    = cnt_width(TIMEOUT);
    localparam int ACC_W = (N > 1) ? (WORD_W - BEAT_W) : 1;

    rx_state_e         state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic              end_q, end_d;
    logic              err_q, err_d;
    logic [ACC_W-1:0]  w_base;
    logic [WORD_W-1:0] w_assembled;
    logic              w_last_beat;

    assign beat_ready_o = rst_ni;
    assign w_base       = (state_q == RX_IDLE) ? '0 : acc_q;
    // cnt_q is zero in idle, so this also marks the single beat when N == 1
    assign w_last_beat  = (cnt_q == CW'(N - 1));

    generate
        if (N > 1) begin : g_multi_beat
            assign w_assembled = {w_base, beat_data_i};
        end else begin : g_single_beat
            assign w_assembled = beat_data_i;
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        acc_d   = acc_q;
        word_d  = word_q;
        end_d   = 1'b0;
        err_d   = 1'b0;
        if (beat_valid_i) begin
            gap_d = '0;
            if (state_q == RX_DROP) begin
                if (beat_last_i) begin
                    state_d = RX_IDLE;
                end
            end else if (w_last_beat) begin
                cnt_d = '0;
                if (beat_last_i) begin
                    word_d  = w_assembled;
                    end_d   = 1'b1;
                    state_d = RX_IDLE;
                end else begin
                    err_d   = 1'b1;
                    state_d = RX_DROP;
                end
            end else if (beat_last_i) begin
                cnt_d   = '0;
                err_d   = 1'b1;
                state_d = RX_IDLE;
            end else begin
                acc_d   = w_assembled[ACC_W-1:0];
                cnt_d   = cnt_q + 1'b1;
                state_d = RX_COLLECT;
            end
        end else if (state_q != RX_IDLE) begin
            if (gap_q == GW'(TIMEOUT - 1)) begin
                err_d   = 1'b1;
                cnt_d   = '0;
                gap_d   = '0;
                state_d = RX_IDLE;
            end else begin
                gap_d = gap_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            gap_q   <= '0;
            acc_q   <= '0;
            word_q  <= '0;
            end_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            acc_q   <= acc_d;
            word_q  <= word_d;
            end_q   <= end_d;
            err_q   <= err_d;
        end
    end

    assign word_o       = word_q;
    assign word_valid_o = end_q;
    assign err_o        = err_q;

endmodule
`default_nettype wire

// File: rtl/sfp_stream_link.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sfp_stream_link : wide word <-> AXI-Stream link (TX serializer top) |
// | Revision        : 1.0                                               |
// +--------------------------------------------------------------------+
module sfp_stream_link
    import sfp_link_pkg::*;
#(
    parameter int C_AXIS_TDATA_WIDTH = 32,
    parameter int C_DATA_STREAM_BIT  = 256,
    parameter int C_RX_TIMEOUT       = 1024
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [C_DATA_STREAM_BIT-1:0]  i_tx_stream_data,
    input  logic                          i_sfp_start_flag,
    output logic [C_DATA_STREAM_BIT-1:0]  o_rx_stream_data,
    output logic                          o_sfp_end_flag,
    output logic                          o_tx_busy,
    output logic                          o_rx_err,
    output logic [C_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    input  logic [C_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    input  logic                          s_axis_tlast
);
    localparam int N  = beats_per_frame(C_DATA_STREAM_BIT, C_AXIS_TDATA_WIDTH);
    localparam int CW = cnt_width(N);

    tx_state_e                    tx_state_q, tx_state_d;
    logic [C_DATA_STREAM_BIT-1:0] tx_sr_q, tx_sr_d;
    logic [CW-1:0]                tx_cnt_q, tx_cnt_d;
    logic                         w_tx_send;
    logic                         w_tx_last;

    assign w_tx_send = (tx_state_q == TX_SEND);
    assign w_tx_last = w_tx_send && (tx_cnt_q == CW'(N - 1));

    always_comb begin
        tx_state_d = tx_state_q;
        tx_sr_d    = tx_sr_q;
        tx_cnt_d   = tx_cnt_q;
        case (tx_state_q)
            TX_IDLE: begin
                if (i_sfp_start_flag) begin
                    tx_sr_d    = i_tx_stream_data;
                    tx_cnt_d   = '0;
                    tx_state_d = TX_SEND;
                end
            end
            TX_SEND: begin
                // Starts arriving here are dropped; the handler must wait for !busy.
                if (m_axis_tready) begin
                    tx_sr_d  = tx_sr_q << C_AXIS_TDATA_WIDTH;
                    tx_cnt_d = tx_cnt_q + 1'b1;
                    if (w_tx_last) begin
                        tx_state_d = TX_IDLE;
                    end
                end
            end
            default: tx_state_d = TX_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            tx_state_q <= TX_IDLE;
            tx_sr_q    <= '0;
            tx_cnt_q   <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_sr_q    <= tx_sr_d;
            tx_cnt_q   <= tx_cnt_d;
        end
    end

    assign m_axis_tdata  = tx_sr_q[C_DATA_STREAM_BIT-1 -: C_AXIS_TDATA_WIDTH];
    assign m_axis_tvalid = w_tx_send;
    assign m_axis_tlast  = w_tx_last;
    assign o_tx_busy     = w_tx_send;

    sfp_stream_deser #(
        .BEAT_W  (C_AXIS_TDATA_WIDTH),
        .WORD_W  (C_DATA_STREAM_BIT),
        .TIMEOUT (C_RX_TIMEOUT)
    ) u_deser (
        .clk_i        (i_clk),
        .rst_ni       (i_rst),
        .beat_data_i  (s_axis_tdata),
        .beat_valid_i (s_axis_tvalid),
        .beat_last_i  (s_axis_tlast),
        .beat_ready_o (s_axis_tready),
        .word_o       (o_rx_stream_data),
        .word_valid_o (o_sfp_end_flag),
        .err_o        (o_rx_err)
    );

endmodule
`default_nettype wire

// File: tb/tb_sfp_stream_link.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_sfp_stream_link : vector table, directed corners, random traffic |
// | Revision           : 1.0                                            |
// +--------------------------------------------------------------------+
module tb_sfp_stream_link;
    localparam int W  = 32;
    localparam int DW = 256;
    localparam int TO = 1024;
    localparam int N  = DW / W;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] i_tx_stream_data = '0;
    logic          i_sfp_start_flag = 1'b0;
    logic [DW-1:0] o_rx_stream_data;
    logic          o_sfp_end_flag, o_tx_busy, o_rx_err;
    logic [W-1:0]  m_axis_tdata;
    logic          m_axis_tvalid, m_axis_tlast;
    logic          m_axis_tready = 1'b0;
    logic [W-1:0]  s_axis_tdata = '0;
    logic          s_axis_tvalid = 1'b0, s_axis_tlast = 1'b0;
    logic          s_axis_tready;

    always #5 clk = ~clk;

    sfp_stream_link #(
        .C_AXIS_TDATA_WIDTH (W),
        .C_DATA_STREAM_BIT  (DW),
        .C_RX_TIMEOUT       (TO)
    ) dut (
        .i_clk            (clk),
        .i_rst            (rst_n),
        .i_tx_stream_data (i_tx_stream_data),
        .i_sfp_start_flag (i_sfp_start_flag),
        .o_rx_stream_data (o_rx_stream_data),
        .o_sfp_end_flag   (o_sfp_end_flag),
        .o_tx_busy        (o_tx_busy),
        .o_rx_err         (o_rx_err),
        .m_axis_tdata     (m_axis_tdata),
        .m_axis_tvalid    (m_axis_tvalid),
        .m_axis_tready    (m_axis_tready),
        .m_axis_tlast     (m_axis_tlast),
        .s_axis_tdata     (s_axis_tdata),
        .s_axis_tvalid    (s_axis_tvalid),
        .s_axis_tready    (s_axis_tready),
        .s_axis_tlast     (s_axis_tlast)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Stimulus for the next cycle
    bit            d_start, d_ready, d_rvalid, d_rlast;
    logic [DW-1:0] d_word;
    logic [W-1:0]  d_rdata;

    // Reference model: TX beats still owed, RX frame in flight
    logic [W-1:0]  tx_q[$];
    bit            tx_prev_stall;
    logic [W-1:0]  tx_prev_data;
    logic [W-1:0]  rx_q[$];
    bit            rx_in_frame, rx_dropping;
    int            rx_idle;
    logic          exp_end, exp_err;
    logic [DW-1:0] exp_word;

    // Observations
    int            cyc, busy_cnt, cnt_end, cnt_err;
    logic [W-1:0]  cap_data[$];
    bit            cap_last[$];
    int            cap_cyc[$];

    function automatic logic [DW-1:0] pack_rx();
        logic [DW-1:0] w = '0;
        foreach (rx_q[i]) w = (w << W) | DW'(rx_q[i]);
        return w;
    endfunction

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] w = '0;
        for (int i = 0; i < N; i++) w = (w << W) | DW'($urandom);
        return w;
    endfunction

    task automatic model_clear();
        tx_q.delete();
        rx_q.delete();
        tx_prev_stall = 1'b0;
        rx_in_frame   = 1'b0;
        rx_dropping   = 1'b0;
        rx_idle       = 0;
        exp_end       = 1'b0;
        exp_err       = 1'b0;
        exp_word      = '0;
    endtask

    task automatic cycle();
        bit busy;
        @(posedge clk);
        #1;
        cyc++;
        busy_cnt += int'(o_tx_busy);
        cnt_end  += int'(o_sfp_end_flag);
        cnt_err  += int'(o_rx_err);
        chk("tx_valid", m_axis_tvalid, tx_q.size() != 0);
        chk("tx_busy", o_tx_busy, tx_q.size() != 0);
        chk("tx_last", m_axis_tlast, tx_q.size() == 1);
        if (tx_prev_stall) chk("tx_hold", m_axis_tdata, tx_prev_data);
        chk("rx_end", o_sfp_end_flag, exp_end);
        chk("rx_err", o_rx_err, exp_err);
        chk("rx_word", o_rx_stream_data, exp_word);
        chk("rx_ready", s_axis_tready, 1'b1);

        i_sfp_start_flag = d_start;
        i_tx_stream_data = d_word;
        m_axis_tready    = d_ready;
        s_axis_tvalid    = d_rvalid;
        s_axis_tlast     = d_rlast;
        s_axis_tdata     = d_rdata;

        busy = (tx_q.size() != 0);
        tx_prev_stall = busy && !d_ready;
        tx_prev_data  = busy ? tx_q[0] : '0;
        if (busy) begin
            chk("tx_data", m_axis_tdata, tx_q[0]);
            if (d_ready) begin
                cap_data.push_back(m_axis_tdata);
                cap_last.push_back(m_axis_tlast);
                cap_cyc.push_back(cyc);
                void'(tx_q.pop_front());
            end
        end
        if (d_start && !busy)
            for (int i = 0; i < N; i++) tx_q.push_back(d_word[DW-1-i*W -: W]);

        exp_end = 1'b0;
        exp_err = 1'b0;
        if (d_rvalid) begin
            rx_idle = 0;
            if (rx_dropping) begin
                if (d_rlast) begin
                    rx_dropping = 1'b0;
                    rx_in_frame = 1'b0;
                end
            end else begin
                rx_q.push_back(d_rdata);
                rx_in_frame = 1'b1;
                if (d_rlast) begin
                    if (rx_q.size() == N) begin
                        exp_end  = 1'b1;
                        exp_word = pack_rx();
                    end else begin
                        exp_err = 1'b1;
                    end
                    rx_q.delete();
                    rx_in_frame = 1'b0;
                end else if (rx_q.size() == N) begin
                    exp_err = 1'b1;
                    rx_q.delete();
                    rx_dropping = 1'b1;
                end
            end
        end else if (rx_in_frame) begin
            rx_idle++;
            if (rx_idle == TO) begin
                exp_err = 1'b1;
                rx_q.delete();
                rx_in_frame = 1'b0;
                rx_dropping = 1'b0;
                rx_idle     = 0;
            end
        end
    endtask

    task automatic rx_send(input logic [W-1:0] data, input bit last, input int gap);
        d_rvalid = 1'b0;
        d_rlast  = 1'b0;
        repeat (gap) cycle();
        d_rvalid = 1'b1;
        d_rdata  = data;
        d_rlast  = last;
        cycle();
        d_rvalid = 1'b0;
        d_rlast  = 1'b0;
    endtask

    task automatic clear_obs();
        cap_data.delete();
        cap_last.delete();
        cap_cyc.delete();
        busy_cnt = 0;
        cnt_end  = 0;
        cnt_err  = 0;
    endtask

    typedef struct {
        logic [DW-1:0] word;
        logic [W-1:0]  first;
        logic [W-1:0]  last;
    } tx_vec_t;

    tx_vec_t tv[3];

    localparam logic [DW-1:0] S3_WORD =
        256'h00000001_00000002_00000003_00000004_00000005_00000006_00000007_00000008;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] good;
        logic [7:0]    lastmask;
        int            start_cyc, rx_pos, rx_len;

        tv[0] = '{256'h00112233_44556677_8899AABB_CCDDEEFF_00112233_44556677_8899AABB_CCDDEEFF,
                  32'h00112233, 32'hCCDDEEFF};
        tv[1] = '{{DW{1'b1}}, 32'hFFFFFFFF, 32'hFFFFFFFF};
        tv[2] = '{256'h80000000_00000000_00000000_00000000_00000000_00000000_00000000_00000001,
                  32'h80000000, 32'h00000001};

        model_clear();
        d_start = 0; d_ready = 0; d_rvalid = 0; d_rlast = 0; d_rdata = '0; d_word = '0;
        cyc = 0;
        clear_obs();

        // Reset state
        #2;
        chk("rst_tvalid", m_axis_tvalid, 1'b0);
        chk("rst_tlast", m_axis_tlast, 1'b0);
        chk("rst_busy", o_tx_busy, 1'b0);
        chk("rst_end", o_sfp_end_flag, 1'b0);
        chk("rst_err", o_rx_err, 1'b0);
        chk("rst_tready", s_axis_tready, 1'b0);
        chk("rst_word", o_rx_stream_data, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) cycle();

        // Vector table: full-rate TX frames
        for (int v = 0; v < 3; v++) begin
            d_ready = 1'b1;
            d_start = 1'b1;
            d_word  = tv[v].word;
            cycle();
            start_cyc = cyc;
            d_start = 1'b0;
            clear_obs();
            repeat (12) cycle();
            chk("tbl_nbeats", cap_data.size(), N);
            if (cap_data.size() == N) begin
                chk("tbl_first", cap_data[0], tv[v].first);
                chk("tbl_lastbeat", cap_data[N-1], tv[v].last);
                chk("tbl_latency", cap_cyc[0] - start_cyc, 1);
                lastmask = '0;
                for (int j = 0; j < N; j++) lastmask[j] = cap_last[j];
                chk("tbl_tlast_mask", lastmask, 8'h80);
            end
            chk("tbl_busy_cycles", busy_cnt, N);
        end

        // Back-pressure 1,0,0,1 with an ignored start mid-frame
        d_start = 1'b1;
        d_word  = tv[0].word;
        d_ready = 1'b1;
        cycle();
        d_start = 1'b0;
        clear_obs();
        for (int i = 0; i < 40; i++) begin
            d_ready = (i % 4 == 0) || (i % 4 == 3);
            d_start = (i == 5);
            d_word  = tv[2].word;
            cycle();
        end
        d_start = 1'b0;
        d_ready = 1'b1;
        chk("bp_nbeats", cap_data.size(), N);
        if (cap_data.size() == N) begin
            chk("bp_first", cap_data[0], 32'h00112233);
            chk("bp_last", cap_data[N-1], 32'hCCDDEEFF);
        end

        // Good RX frame with gaps, one just under the timeout
        clear_obs();
        for (int b = 1; b <= N; b++)
            rx_send(W'(b), b == N, (b == 4) ? TO - 1 : int'($urandom_range(0, 4)));
        cycle();
        chk("s3_word", o_rx_stream_data, S3_WORD);
        repeat (3) cycle();
        chk("s3_end_count", cnt_end, 1);
        chk("s3_err_count", cnt_err, 0);

        // Short frame, then an over-long frame
        clear_obs();
        for (int b = 1; b <= 5; b++) rx_send(32'hA0 + W'(b), b == 5, 0);
        repeat (3) cycle();
        chk("short_err_count", cnt_err, 1);
        chk("short_end_count", cnt_end, 0);
        chk("short_word_hold", o_rx_stream_data, S3_WORD);
        clear_obs();
        for (int b = 1; b <= 9; b++) rx_send(32'hB0 + W'(b), b == 9, int'($urandom_range(0, 2)));
        repeat (3) cycle();
        chk("long_err_count", cnt_err, 1);
        chk("long_end_count", cnt_end, 0);
        chk("long_word_hold", o_rx_stream_data, S3_WORD);

        // Timeout mid-frame, then recovery
        clear_obs();
        for (int b = 1; b <= 3; b++) rx_send(32'hC0 + W'(b), 1'b0, 0);
        repeat (TO + 5) cycle();
        chk("to_err_count", cnt_err, 1);
        clear_obs();
        good = '0;
        for (int b = 0; b < N; b++) begin
            d_rdata = $urandom;
            good = (good << W) | DW'(d_rdata);
            rx_send(d_rdata, b == N - 1, int'($urandom_range(0, 3)));
        end
        cycle();
        chk("to_recover_word", o_rx_stream_data, good);
        chk("to_recover_end", cnt_end, 1);

        // Asynchronous reset during TX beat 5 and an RX frame
        d_ready = 1'b1;
        d_start = 1'b1;
        d_word  = tv[0].word;
        d_rvalid = 1'b1; d_rlast = 1'b0; d_rdata = 32'hD1;
        cycle();
        d_start = 1'b0;
        for (int b = 2; b <= 5; b++) begin
            d_rdata = 32'hD0 + W'(b);
            cycle();
        end
        d_rvalid = 1'b0;
        @(posedge clk);
        #2;
        chk("pre_rst_tvalid", m_axis_tvalid, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_tvalid", m_axis_tvalid, 1'b0);
        chk("arst_tlast", m_axis_tlast, 1'b0);
        chk("arst_busy", o_tx_busy, 1'b0);
        chk("arst_end", o_sfp_end_flag, 1'b0);
        chk("arst_tready", s_axis_tready, 1'b0);
        chk("arst_word", o_rx_stream_data, '0);
        model_clear();
        d_ready = 0; d_rvalid = 0; d_rlast = 0;
        m_axis_tready = 0; s_axis_tvalid = 0; s_axis_tlast = 0; i_sfp_start_flag = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_obs();
        d_ready = 1'b1;
        d_start = 1'b1;
        d_word  = tv[2].word;
        cycle();
        d_start = 1'b0;
        for (int b = 1; b <= N; b++) rx_send(W'(b), b == N, 0);
        repeat (4) cycle();
        chk("post_rst_tx_beats", cap_data.size(), N);
        chk("post_rst_rx_word", o_rx_stream_data, S3_WORD);
        chk("post_rst_end", cnt_end, 1);

        // Random concurrent traffic checked against the model
        rx_pos = 0;
        rx_len = N;
        for (int c = 0; c < 800; c++) begin
            d_start  = ($urandom_range(0, 5) == 0);
            d_word   = rand_word();
            d_ready  = $urandom_range(0, 1) != 0;
            d_rvalid = $urandom_range(0, 2) != 0;
            d_rdata  = $urandom;
            if (d_rvalid) begin
                d_rlast = (rx_pos == rx_len - 1);
                if (d_rlast) begin
                    rx_pos = 0;
                    case ($urandom_range(0, 5))
                        0:       rx_len = 3;
                        1:       rx_len = 10;
                        default: rx_len = N;
                    endcase
                end else begin
                    rx_pos++;
                end
            end else begin
                d_rlast = $urandom_range(0, 1) != 0;
            end
            cycle();
        end
        d_start = 0; d_rvalid = 0; d_rlast = 0; d_ready = 1;
        repeat (20) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sfp_stream_link.md
Name: sfp_stream_link

Overview:
Link-side counterpart of the SFP data handler. It takes the wide stream word plus a one-cycle start flag from the handler and serializes it as AXI-Stream beats toward the SFP transceiver/Aurora core. In the other direction it reassembles received AXI-Stream beats into one wide word and returns it with a one-cycle end flag. It sits between the handler (wide-word side) and the transceiver user interface (AXIS side).

Parameters:
C_AXIS_TDATA_WIDTH, 32, AXIS beat width in bits
C_DATA_STREAM_BIT, 256, wide stream word width; must be an integer multiple of C_AXIS_TDATA_WIDTH
C_RX_TIMEOUT, 1024, maximum idle cycles between RX beats inside a frame before the frame is dropped

Ports:
i_clk  in  1  system clock
i_rst  in  1  asynchronous active-low reset
i_tx_stream_data  in  C_DATA_STREAM_BIT  word to transmit, sampled on start
i_sfp_start_flag  in  1  one-cycle request to transmit
o_rx_stream_data  out  C_DATA_STREAM_BIT  last correctly received word
o_sfp_end_flag  out  1  one-cycle pulse: new word valid on o_rx_stream_data
o_tx_busy  out  1  TX frame in progress
o_rx_err  out  1  one-cycle pulse on any dropped RX frame
m_axis_tdata  out  C_AXIS_TDATA_WIDTH  TX beat data
m_axis_tvalid  out  1  TX beat valid
m_axis_tready  in  1  TX beat accepted by transceiver
m_axis_tlast  out  1  final beat of TX frame
s_axis_tdata  in  C_AXIS_TDATA_WIDTH  RX beat data
s_axis_tvalid  in  1  RX beat valid
s_axis_tready  out  1  RX ready
s_axis_tlast  in  1  final beat of RX frame

Behaviour:
- N = C_DATA_STREAM_BIT / C_AXIS_TDATA_WIDTH beats per frame. Beat order is MSB-first: beat 0 = bits [C_DATA_STREAM_BIT-1 -: C_AXIS_TDATA_WIDTH].
- Reset (async, i_rst=0): all outputs 0, except s_axis_tready = 0 while in reset. Both FSMs go to idle, shift registers and counters cleared. Reset mid-frame aborts the frame; m_axis_tvalid drops immediately.
- TX FSM, states TX_IDLE and TX_SEND:
  - TX_IDLE: i_sfp_start_flag=1 latches i_tx_stream_data into the TX shift register, clears the beat counter and goes to TX_SEND. m_axis_tvalid=1 and o_tx_busy=1 in the next cycle (latency 1).
  - TX_SEND: m_axis_tdata = top beat of the shift register. Data and tvalid are held stable while tready=0. On tvalid&tready the register shifts left by C_AXIS_TDATA_WIDTH and the counter increments.
  - m_axis_tlast=1 only when counter = N-1. Acceptance of the tlast beat returns the FSM to TX_IDLE; tvalid=0 next cycle.
  - i_sfp_start_flag while in TX_SEND is ignored (no queueing). Back-to-back: a start in the cycle after return to idle is accepted.
- RX FSM, states RX_IDLE, RX_COLLECT and RX_DROP:
  - s_axis_tready=1 in all states out of reset. A beat is accepted on s_axis_tvalid=1.
  - RX_IDLE: the first beat goes into the accumulator, count=1, then RX_COLLECT.
  - RX_COLLECT: each beat shifts the accumulator left and inserts the beat in the LSBs; count increments.
  - Beat number N with tlast=1 (good frame): o_rx_stream_data <= assembled word and o_sfp_end_flag=1 for exactly one cycle, both in the cycle after the beat (latency 1). Then RX_IDLE.
  - tlast=1 with count<N: frame discarded, o_rx_err pulse, RX_IDLE.
  - Beat N with tlast=0: o_rx_err pulse, then RX_DROP. RX_DROP discards beats until a tlast beat is accepted, then RX_IDLE.
  - N=1: a single tlast beat is a good frame.
  - In RX_COLLECT or RX_DROP, a gap counter counts cycles without a valid beat. Reaching C_RX_TIMEOUT discards the frame, pulses o_rx_err and returns to RX_IDLE. A valid beat clears the counter.
  - o_rx_stream_data changes only on good frames; it holds its value otherwise.
- TX and RX are fully independent and run concurrently.

Decomposition:
- Shared package sfp_link_pkg: FSM state encodings (TX_IDLE/TX_SEND, RX_IDLE/RX_COLLECT/RX_DROP), the beats-per-frame constant function, and the beat-counter width function clog2(N).
- One natural sub-module: sfp_stream_deser, the RX assembler with timeout. TX serializer stays in the top.

Test Plan:
1. Defaults, tready=1, start with data 0x0011..EEFF (256b): exactly 8 beats starting 1 cycle after start. First beat = 0x001122 33, tlast only on beat 8, o_tx_busy high for 8 cycles.
2. tready toggled 1,0,0,1,... during TX: every stalled beat holds tdata/tvalid stable, no beat lost or duplicated, and a second start during the frame is ignored.
3. RX 8 beats 0x00000001..0x00000008 with tlast on beat 8, random tvalid gaps <1024: o_rx_stream_data = 0x00000001_..._00000008 and a single end_flag pulse 1 cycle after beat 8.
4. RX tlast on beat 5: o_rx_err pulse, no end_flag, o_rx_stream_data unchanged. Then 9 beats with tlast on beat 9: err pulse, drop until tlast, no end_flag.
5. RX 3 beats then 1024 idle cycles: o_rx_err pulse on timeout. A following good 8-beat frame is received correctly.
6. Assert i_rst=0 mid-TX (beat 4) and mid-RX: tvalid/tlast/end_flag go to 0 asynchronously. After release a full TX and a full RX frame complete normally.
